// File: rtl/load_store_queue.sv
// In-order load/store queue: allocates at dispatch, collects address/data from the
// calculator, issues head-only to dmem with one access outstanding, and broadcasts on the CDB.
// Optional LSQ_LOAD_FASTPATH_EN: a head load issues in the same cycle as its calc write.
module load_store_queue #(
    parameter int DEPTH     = 8,
    parameter int ROB_IDX_W = 5,
    parameter int PREG_W    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic                     alloc_is_store,
    input  logic [2:0]               alloc_funct3,
    input  logic [ROB_IDX_W-1:0]     alloc_rob_id,
    input  logic [PREG_W-1:0]        alloc_pd,
    output logic                     alloc_ready,
    output logic [$clog2(DEPTH)-1:0] alloc_lsq_id,
    input  logic                     calc_valid,
    input  logic [$clog2(DEPTH)-1:0] calc_lsq_id,
    input  logic [31:0]              calc_addr,
    input  logic [3:0]               calc_mask,
    input  logic [31:0]              calc_wdata,
    input  logic [ROB_IDX_W-1:0]     rob_head_id,
    output logic [31:0]              dmem_addr,
    output logic [3:0]               dmem_rmask,
    output logic [3:0]               dmem_wmask,
    output logic [31:0]              dmem_wdata,
    input  logic [31:0]              dmem_rdata,
    input  logic                     dmem_resp,
    output logic                     cdb_valid,
    output logic [ROB_IDX_W-1:0]     cdb_rob_id,
    output logic [PREG_W-1:0]        cdb_pd,
    output logic [31:0]              cdb_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    state_t               state_q, state_d;
    logic [IDX_W:0]       head_q, head_d, tail_q, tail_d;
    logic [IDX_W-1:0]     head_idx, tail_idx;
    logic [DEPTH-1:0]     valid_q, valid_d, is_store_q, is_store_d, addr_valid_q, addr_valid_d;
    logic [2:0]           funct3_q [DEPTH];
    logic [2:0]           funct3_d [DEPTH];
    logic [ROB_IDX_W-1:0] rob_id_q [DEPTH];
    logic [ROB_IDX_W-1:0] rob_id_d [DEPTH];
    logic [PREG_W-1:0]    pd_q     [DEPTH];
    logic [PREG_W-1:0]    pd_d     [DEPTH];
    logic [31:0]          addr_q   [DEPTH];
    logic [31:0]          addr_d   [DEPTH];
    logic [3:0]           mask_q   [DEPTH];
    logic [3:0]           mask_d   [DEPTH];
    logic [31:0]          wdata_q  [DEPTH];
    logic [31:0]          wdata_d  [DEPTH];

    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [PREG_W-1:0]    cdb_pd_q, cdb_pd_d;
    logic [31:0]          cdb_data_q, cdb_data_d;

    logic        full, head_ready, fast_hit, issue;
    logic [31:0] issue_addr;
    logic [3:0]  issue_mask;

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    // Stores wait for the ROB head so they never write speculatively.
    assign head_ready = valid_q[head_idx] && addr_valid_q[head_idx] &&
                        (!is_store_q[head_idx] || (rob_id_q[head_idx] == rob_head_id));

`ifdef LSQ_LOAD_FASTPATH_EN
    assign fast_hit = valid_q[head_idx] && !is_store_q[head_idx] && !addr_valid_q[head_idx] &&
                      calc_valid && (calc_lsq_id == head_idx);
`else
    assign fast_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        valid_d      = valid_q;
        is_store_d   = is_store_q;
        addr_valid_d = addr_valid_q;
        funct3_d     = funct3_q;
        rob_id_d     = rob_id_q;
        pd_d         = pd_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        cdb_valid_d  = 1'b0;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_pd_d     = cdb_pd_q;
        cdb_data_d   = cdb_data_q;
        issue        = 1'b0;
        issue_addr   = addr_q[head_idx];
        issue_mask   = mask_q[head_idx];

        if (alloc_valid && alloc_ready) begin
            valid_d[tail_idx]      = 1'b1;
            is_store_d[tail_idx]   = alloc_is_store;
            addr_valid_d[tail_idx] = 1'b0;
            funct3_d[tail_idx]     = alloc_funct3;
            rob_id_d[tail_idx]     = alloc_rob_id;
            pd_d[tail_idx]         = alloc_pd;
            tail_d                 = tail_q + PTR_ONE;
        end

        if (calc_valid) begin
            addr_valid_d[calc_lsq_id] = 1'b1;
            addr_d[calc_lsq_id]       = calc_addr;
            mask_d[calc_lsq_id]       = calc_mask;
            wdata_d[calc_lsq_id]      = calc_wdata;
        end

        case (state_q)
            IDLE: begin
                if (!rst && (head_ready || fast_hit)) begin
                    issue   = 1'b1;
                    state_d = MEM_WAIT;
                    if (fast_hit) begin
                        issue_addr = calc_addr;
                        issue_mask = calc_mask;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_resp) begin
                    valid_d[head_idx] = 1'b0;
                    head_d            = head_q + PTR_ONE;
                    state_d           = IDLE;
                    cdb_valid_d       = 1'b1;
                    cdb_rob_id_d      = rob_id_q[head_idx];
                    cdb_pd_d          = is_store_q[head_idx] ? '0 : pd_q[head_idx];
                    cdb_data_d        = is_store_q[head_idx] ? 32'h0 :
                                        load_extend(funct3_q[head_idx], addr_q[head_idx][1:0],
                                                    dmem_rdata);
                end
            end
        endcase
    end

    assign alloc_ready  = !full && !rst;
    assign alloc_lsq_id = tail_idx;
    assign dmem_addr    = issue_addr & 32'hFFFF_FFFC;
    assign dmem_rmask   = (issue && !is_store_q[head_idx]) ? issue_mask : 4'b0000;
    assign dmem_wmask   = (issue &&  is_store_q[head_idx]) ? issue_mask : 4'b0000;
    assign dmem_wdata   = wdata_q[head_idx];
    assign cdb_valid    = cdb_valid_q && !rst;
    assign cdb_rob_id   = cdb_rob_id_q;
    assign cdb_pd       = cdb_pd_q;
    assign cdb_data     = cdb_data_q;

    // NOTE: sequential state is written with <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            addr_valid_q <= '0;
            cdb_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            addr_valid_q <= addr_valid_d;
            cdb_valid_q  <= cdb_valid_d;
        end
    end

    // NOTE: entry payload and CDB payload are not reset; valid/addr_valid/cdb_valid qualify them.
    always_ff @(posedge clk) begin
        is_store_q   <= is_store_d;
        funct3_q     <= funct3_d;
        rob_id_q     <= rob_id_d;
        pd_q         <= pd_d;
        addr_q       <= addr_d;
        mask_q       <= mask_d;
        wdata_q      <= wdata_d;
        cdb_rob_id_q <= cdb_rob_id_d;
        cdb_pd_q     <= cdb_pd_d;
        cdb_data_q   <= cdb_data_d;
    end

    calc_targets_valid_entry: assert property (@(posedge clk) disable iff (rst)
        calc_valid |-> valid_q[calc_lsq_id]);

endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: directed stimulus pushes expected dmem requests and
// CDB broadcasts; a monitor pops and compares them; a small memory responder answers requests.
module tb_load_store_queue;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          cyc;
    } req_t;

    typedef struct {
        logic [4:0]  rob;
        logic [5:0]  pd;
        logic [31:0] data;
    } cdb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid, alloc_is_store;
    logic [2:0]  alloc_funct3;
    logic [4:0]  alloc_rob_id;
    logic [5:0]  alloc_pd;
    logic        alloc_ready;
    logic [2:0]  alloc_lsq_id;
    logic        calc_valid;
    logic [2:0]  calc_lsq_id;
    logic [31:0] calc_addr, calc_wdata;
    logic [3:0]  calc_mask;
    logic [4:0]  rob_head_id;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [5:0]  cdb_pd;
    logic [31:0] cdb_data;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    req_t        exp_req[$];
    cdb_t        exp_cdb[$];
    logic [31:0] mem [logic [31:0]];
    logic        mem_hold = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    load_store_queue dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store), .alloc_funct3(alloc_funct3),
        .alloc_rob_id(alloc_rob_id), .alloc_pd(alloc_pd), .alloc_ready(alloc_ready),
        .alloc_lsq_id(alloc_lsq_id),
        .calc_valid(calc_valid), .calc_lsq_id(calc_lsq_id), .calc_addr(calc_addr),
        .calc_mask(calc_mask), .calc_wdata(calc_wdata), .rob_head_id(rob_head_id),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_pd(cdb_pd), .cdb_data(cdb_data)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers the request seen in cycle I with dmem_resp in cycle I+1.
    initial begin
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && (dmem_rmask != 4'b0 || dmem_wmask != 4'b0)) begin
                pend      = 1'b1;
                pend_addr = dmem_addr;
            end
            @(posedge clk);
            #1;
            dmem_resp = 1'b0;
            if (rst) pend = 1'b0;
            else if (pend && !mem_hold) begin
                dmem_resp  = 1'b1;
                dmem_rdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                pend       = 1'b0;
            end
        end
    end

    // Monitor: compares every presented request and broadcast against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (dmem_rmask != 4'b0 || dmem_wmask != 4'b0) begin
                if (exp_req.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_req: got addr 0x%08h r%b w%b, required no request",
                             dmem_addr, dmem_rmask, dmem_wmask);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    check("req_addr", dmem_addr, e.addr);
                    check("req_masks", {24'h0, dmem_rmask, dmem_wmask}, {24'h0, e.rmask, e.wmask});
                    if (e.wmask != 4'b0) check("req_wdata", dmem_wdata, e.wdata);
                    if (e.cyc >= 0) check("req_cycle", cyc, e.cyc);
                end
            end
            if (cdb_valid) begin
                if (exp_cdb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_cdb: got rob %0d data 0x%08h, required none",
                             cdb_rob_id, cdb_data);
                end else begin
                    cdb_t c;
                    c = exp_cdb.pop_front();
                    check("cdb_rob_id", {27'h0, cdb_rob_id}, {27'h0, c.rob});
                    check("cdb_pd", {26'h0, cdb_pd}, {26'h0, c.pd});
                    check("cdb_data", cdb_data, c.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic push_exp(input logic [31:0] a, input logic [3:0] m, input logic st,
                            input logic [31:0] wd, input logic [4:0] rob, input logic [5:0] pd,
                            input logic [31:0] data, input int c, input bit want_cdb);
        req_t r;
        cdb_t d;
        r.addr  = a & 32'hFFFF_FFFC;
        r.rmask = st ? 4'b0 : m;
        r.wmask = st ? m : 4'b0;
        r.wdata = wd;
        r.cyc   = c;
        exp_req.push_back(r);
        d.rob  = rob;
        d.pd   = pd;
        d.data = data;
        if (want_cdb) exp_cdb.push_back(d);
    endtask

    task automatic do_alloc(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                            input logic [5:0] pd, input logic [2:0] exp_id);
        for (int k = 0; k < 50 && !alloc_ready; k++) tick();
        check("alloc_id", {29'h0, alloc_lsq_id}, {29'h0, exp_id});
        alloc_valid    = 1'b1;
        alloc_is_store = st;
        alloc_funct3   = f3;
        alloc_rob_id   = rob;
        alloc_pd       = pd;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_calc(input logic [2:0] id, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] wd);
        calc_valid  = 1'b1;
        calc_lsq_id = id;
        calc_addr   = a;
        calc_mask   = m;
        calc_wdata  = wd;
        tick();
        calc_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 300 && (exp_req.size() != 0 || exp_cdb.size() != 0); k++) tick();
        check(name, exp_req.size() + exp_cdb.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_alloc_ready", {31'h0, alloc_ready}, 0);
        check("rst_masks", {24'h0, dmem_rmask, dmem_wmask}, 0);
        check("rst_cdb_valid", {31'h0, cdb_valid}, 0);
        tick();
        tick();
        exp_req.delete();
        exp_cdb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cdb_valid", {31'h0, cdb_valid}, 0);
        check("post_rst_masks", {24'h0, dmem_rmask, dmem_wmask}, 0);
        check("post_rst_lsq_id", {29'h0, alloc_lsq_id}, 0);
        check("post_rst_ready", {31'h0, alloc_ready}, 1);
        tick();
    endtask

    initial begin
        int exp_cyc;
        alloc_valid = 0; alloc_is_store = 0; alloc_funct3 = 0; alloc_rob_id = 0; alloc_pd = 0;
        calc_valid = 0; calc_lsq_id = 0; calc_addr = 0; calc_mask = 0; calc_wdata = 0;
        rob_head_id = 5'd0;
        rst = 1'b1;
        mem[32'h1000] = 32'h80FF_0000;
        mem[32'h3000] = 32'h9A00_0000;
        mem[32'h4000] = 32'h0BAD_F00D;
        mem[32'h4004] = 32'h1234_5678;
        mem[32'h4008] = 32'hCAFE_0001;
        mem[32'h6000] = 32'h5555_AAAA;
        for (int i = 0; i < 10; i++) mem[32'h5000 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
        do_reset();

        // lh at offset 2: request timing and sign extension.
        do_alloc(1'b0, 3'b001, 5'd1, 6'd9, 3'd0);
`ifdef LSQ_LOAD_FASTPATH_EN
        exp_cyc = cyc;
`else
        exp_cyc = cyc + 1;
`endif
        push_exp(32'h1002, 4'b0011, 1'b0, 32'h0, 5'd1, 6'd9, 32'hFFFF_80FF, exp_cyc, 1'b1);
        do_calc(3'd0, 32'h1002, 4'b0011, 32'h0);
        drain("drain_lh");

        // Store held until it reaches the ROB head.
        rob_head_id = 5'd2;
        do_alloc(1'b1, 3'b010, 5'd3, 6'd7, 3'd1);
        do_calc(3'd1, 32'h2000, 4'b1111, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("store_held", {28'h0, dmem_wmask}, 0);
            tick();
        end
        push_exp(32'h2000, 4'b1111, 1'b1, 32'hDEAD_BEEF, 5'd3, 6'd0, 32'h0, cyc, 1'b1);
        rob_head_id = 5'd3;
        drain("drain_store");

        // Fill, blocked allocation, partial drain, wrap-around allocation, in-order issue.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(1'b0, 3'b010, 5'(8 + i), 6'(20 + i), 3'(i));
        check("full_ready", {31'h0, alloc_ready}, 0);
        alloc_valid = 1'b1; alloc_is_store = 1'b0; alloc_funct3 = 3'b010;
        alloc_rob_id = 5'd31; alloc_pd = 6'd63;
        tick();
        alloc_valid = 1'b0;
        check("full_tail", {29'h0, alloc_lsq_id}, 0);
        check("still_full", {31'h0, alloc_ready}, 0);
        for (int i = 0; i < 2; i++) begin
            push_exp(32'h5000 + 32'(4 * i), 4'b1111, 1'b0, 32'h0, 5'(8 + i), 6'(20 + i),
                     32'hA000_0000 + 32'(i), -1, 1'b1);
            do_calc(3'(i), 32'h5000 + 32'(4 * i), 4'b1111, 32'h0);
        end
        drain("drain_first_two");
        do_alloc(1'b0, 3'b010, 5'd16, 6'd28, 3'd0);
        do_alloc(1'b0, 3'b010, 5'd17, 6'd29, 3'd1);
        check("tail_wrapped", {29'h0, alloc_lsq_id}, 2);
        for (int i = 2; i < 10; i++) begin
            push_exp(32'h5000 + 32'(4 * i), 4'b1111, 1'b0, 32'h0, 5'(8 + i), 6'(20 + i),
                     32'hA000_0000 + 32'(i), -1, 1'b1);
            do_calc(3'(i % 8), 32'h5000 + 32'(4 * i), 4'b1111, 32'h0);
        end
        drain("drain_wrap");

        // Out-of-order calc: entry 2, then 1, then 0; issue must stay 0, 1, 2.
        do_reset();
        do_alloc(1'b0, 3'b010, 5'd1, 6'd1, 3'd0);
        do_alloc(1'b0, 3'b010, 5'd2, 6'd2, 3'd1);
        do_alloc(1'b0, 3'b010, 5'd4, 6'd3, 3'd2);
        do_calc(3'd2, 32'h4008, 4'b1111, 32'h0);
        tick();
        @(negedge clk);
        check("ooo_hold_2", {28'h0, dmem_rmask}, 0);
        tick();
        do_calc(3'd1, 32'h4004, 4'b1111, 32'h0);
        tick();
        @(negedge clk);
        check("ooo_hold_1", {28'h0, dmem_rmask}, 0);
        tick();
        push_exp(32'h4000, 4'b1111, 1'b0, 32'h0, 5'd1, 6'd1, 32'h0BAD_F00D, -1, 1'b1);
        push_exp(32'h4004, 4'b1111, 1'b0, 32'h0, 5'd2, 6'd2, 32'h1234_5678, -1, 1'b1);
        push_exp(32'h4008, 4'b1111, 1'b0, 32'h0, 5'd4, 6'd3, 32'hCAFE_0001, -1, 1'b1);
        do_calc(3'd0, 32'h4000, 4'b1111, 32'h0);
        drain("drain_ooo");

        // Sub-word extension at offsets 3 and 2 of 0x9A00_0000.
        do_alloc(1'b0, 3'b000, 5'd20, 6'd40, 3'd3);
        do_alloc(1'b0, 3'b100, 5'd21, 6'd41, 3'd4);
        do_alloc(1'b0, 3'b001, 5'd22, 6'd42, 3'd5);
        do_alloc(1'b0, 3'b101, 5'd23, 6'd43, 3'd6);
        push_exp(32'h3003, 4'b1000, 1'b0, 32'h0, 5'd20, 6'd40, 32'hFFFF_FF9A, -1, 1'b1);
        do_calc(3'd3, 32'h3003, 4'b1000, 32'h0);
        push_exp(32'h3003, 4'b1000, 1'b0, 32'h0, 5'd21, 6'd41, 32'h0000_009A, -1, 1'b1);
        do_calc(3'd4, 32'h3003, 4'b1000, 32'h0);
        push_exp(32'h3002, 4'b1100, 1'b0, 32'h0, 5'd22, 6'd42, 32'hFFFF_9A00, -1, 1'b1);
        do_calc(3'd5, 32'h3002, 4'b1100, 32'h0);
        push_exp(32'h3002, 4'b1100, 1'b0, 32'h0, 5'd23, 6'd43, 32'h0000_9A00, -1, 1'b1);
        do_calc(3'd6, 32'h3002, 4'b1100, 32'h0);
        drain("drain_ext");

        // Reset while waiting on memory: nothing may complete afterwards.
        mem_hold = 1'b1;
        do_alloc(1'b0, 3'b010, 5'd9, 6'd9, 3'd7);
        push_exp(32'h6000, 4'b1111, 1'b0, 32'h0, 5'd9, 6'd9, 32'h0, -1, 1'b0);
        do_calc(3'd7, 32'h6000, 4'b1111, 32'h0);
        tick();
        tick();
        @(negedge clk);
        check("wait_masks", {24'h0, dmem_rmask, dmem_wmask}, 0);
        check("wait_req_seen", exp_req.size(), 0);
        tick();
        do_reset();
        mem_hold = 1'b0;
        repeat (6) tick();
        check("final_queues", exp_req.size() + exp_cdb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
